// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing one register write port among N_REQ requesters
module reg_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   din_bus_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic                      en_o,
  output logic [DATA_W-1:0]         dout_o,
  output logic                      busy_o
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_e;
  state_e              state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       win_d;
  logic [3:0]          cnt_q;
  logic [N_REQ-1:0]    gnt_q;
  logic                en_q;
  logic [DATA_W-1:0]   dout_q;
  // Scan from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    win_d = ptr_q;
    for (int i = N_REQ; i >= 1; i--)
      if (req_i[(int'(ptr_q) + i) % N_REQ]) win_d = PW'((int'(ptr_q) + i) % N_REQ);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          gnt_q   <= N_REQ'(1) << win_d;
          en_q    <= 1'b1;
          dout_q  <= din_bus_i[win_d*DATA_W +: DATA_W];
          ptr_q   <= win_d;
          state_q <= WRITE;
        end
        WRITE: begin
          en_q <= 1'b0;
          if (HOLD_CYC == 0) begin
            gnt_q   <= '0;
            dout_q  <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= 4'(HOLD_CYC);
            state_q <= HOLD;
          end
        end
        HOLD: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            gnt_q   <= '0;
            dout_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt_o  = gnt_q;
  assign en_o   = en_q;
  assign dout_o = dout_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenario checks for reg_write_arbiter (HOLD_CYC=2 and HOLD_CYC=0)
module tb_reg_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, req_z = '0;
  logic [31:0] din = '0, din_z = '0;
  logic [3:0]  gnt, gnt_z;
  logic        en, en_z, busy, busy_z;
  logic [7:0]  dout, dout_z;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .din_bus_i(din),
    .gnt_o(gnt), .en_o(en), .dout_o(dout), .busy_o(busy));

  reg_write_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(0)) u_dut_z (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_z), .din_bus_i(din_z),
    .gnt_o(gnt_z), .en_o(en_z), .dout_o(dout_z), .busy_o(busy_z));

  task automatic test_reset;
    rst_n = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt, en, dout, busy} !== 14'd0) begin
        errors++;
        $display("FAIL reset: gnt=%b en=%b dout=%h busy=%b, required all 0", gnt, en, dout, busy);
      end
    end
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    din = 32'h00A5_0000;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if ({gnt, en, dout, busy} !== {4'b0100, 1'b1, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL single_write: gnt=%b en=%b dout=%h busy=%b, required 0100 1 a5 1", gnt, en, dout, busy);
    end
    req = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({gnt, en, dout, busy} !== {4'b0100, 1'b0, 8'hA5, 1'b1}) begin
        errors++;
        $display("FAIL single_hold%0d: gnt=%b en=%b dout=%h busy=%b, required 0100 0 a5 1", c, gnt, en, dout, busy);
      end
    end
    @(negedge clk);
    checks++;
    if ({gnt, en, dout, busy} !== 14'd0) begin
      errors++;
      $display("FAIL single_idle: gnt=%b en=%b dout=%h busy=%b, required all 0", gnt, en, dout, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int n = 0;
    int last = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (gnt != 4'b0)) begin
        errors++;
        $display("FAIL rr_busy_c%0d: busy=%b gnt=%b, required busy==(gnt!=0)", c, busy, gnt);
      end
      if (en === 1'b1) begin
        checks++;
        if (n > 4 || gnt !== exp_g[n > 4 ? 4 : n]) begin
          errors++;
          $display("FAIL rr_grant%0d: gnt=%b, required %b", n, gnt, exp_g[n > 4 ? 4 : n]);
        end
        if (n > 0) begin
          checks++;
          if (c - last != 4) begin
            errors++;
            $display("FAIL rr_spacing%0d: spacing=%0d, required 4", n, c - last);
          end
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_count: pulses=%0d, required 5", n);
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrap;
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_setup: gnt=%b, required 1000", gnt);
    end
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || en !== 1'b1) begin
      errors++;
      $display("FAIL wrap_grant: gnt=%b en=%b, required 0001 1", gnt, en);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold_ignore;
    din = 32'h0000_003C;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || dout !== 8'h3C) begin
      errors++;
      $display("FAIL hold_first: gnt=%b dout=%h, required 0001 3c", gnt, dout);
    end
    req = '0;
    @(negedge clk);
    req = 4'b1000;
    din = 32'h7700_003C;
    @(negedge clk);
    checks++;
    if ({gnt, en, dout} !== {4'b0001, 1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL hold_frozen: gnt=%b en=%b dout=%h, required 0001 0 3c", gnt, en, dout);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle_gap: gnt=%b busy=%b, required 0000 0", gnt, busy);
    end
    @(negedge clk);
    checks++;
    if ({gnt, en, dout} !== {4'b1000, 1'b1, 8'h77}) begin
      errors++;
      $display("FAIL hold_next: gnt=%b en=%b dout=%h, required 1000 1 77", gnt, en, dout);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset;
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL async_setup: gnt=%b, required 0010", gnt);
    end
    req = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, en, dout, busy} !== 14'd0) begin
      errors++;
      $display("FAIL async_clear: gnt=%b en=%b dout=%h busy=%b, required all 0", gnt, en, dout, busy);
    end
    #1 rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || en !== 1'b1) begin
      errors++;
      $display("FAIL async_restart: gnt=%b en=%b, required 0001 1", gnt, en);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold_zero;
    logic [3:0] exp_g [3] = '{4'b0001, 4'b0010, 4'b0100};
    req_z = 4'b1111;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (c % 2 == 1) begin
        if (en_z !== 1'b1 || gnt_z !== exp_g[(c - 1) / 2]) begin
          errors++;
          $display("FAIL hold0_c%0d: en=%b gnt=%b, required 1 %b", c, en_z, gnt_z, exp_g[(c - 1) / 2]);
        end
      end else if (en_z !== 1'b0 || gnt_z !== 4'b0000) begin
        errors++;
        $display("FAIL hold0_c%0d: en=%b gnt=%b, required 0 0000", c, en_z, gnt_z);
      end
    end
    req_z = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold_ignore();
    test_async_reset();
    test_hold_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
